// File: rtl/spi_sram_slave_p.sv
// SPI SRAM slave: decodes READ/WRITE/RDMR/WRMR frames clocked on clk and framed
// by cs_n into byte accesses on a synchronous single-port memory (23LC-style modes).
module spi_sram_slave_p #(
  parameter int ADDR_BYTES = 3,
  parameter int PAGE_SIZE  = 32,
  parameter int READ_GAP   = 2,
  localparam int AW        = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [1:0]    mode
);

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  localparam int CMAX   = (AW > READ_GAP) ? AW : READ_GAP;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int PF_CNT = (READ_GAP > 2) ? READ_GAP - 3 : 0;
  localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_GAP,
    S_RDATA,
    S_WDATA,
    S_MRD,
    S_MWR,
    S_IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_rd_q, is_rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      mode_q, mode_d;
  logic            miso_q, miso_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_wr_q, mem_wr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      tx_q, tx_d;
  logic [AW-1:0]   rx_q;
  logic [AW-1:0]   rx_next;

  // Page mode wraps inside the page; every other non-byte mode (01, 11) is sequential.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] m);
    logic [AW-1:0] inc;
    inc = a + 1'b1;
    if (m == MODE_PAGE) next_addr = (a & ~PMASK) | (inc & PMASK);
    else                next_addr = inc;
  endfunction

  assign rx_next   = {rx_q[AW-2:0], mosi};
  assign miso      = miso_q;
  assign mem_addr  = addr_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = wdata_q;
  assign mode      = mode_q;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    is_rd_d  = is_rd_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    miso_d   = 1'b0;
    mem_en_d = 1'b0;
    mem_wr_d = 1'b0;
    wdata_d  = wdata_q;
    tx_d     = tx_q;
    if (cs_n) begin
      state_d = S_IDLE;
      bit_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          bit_d   = 3'd1;
        end
        S_CMD: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            cnt_d = '0;
            bit_d = '0;
            case (rx_next[7:0])
              OP_READ: begin
                state_d = S_ADDR;
                is_rd_d = 1'b1;
              end
              OP_WRITE: begin
                state_d = S_ADDR;
                is_rd_d = 1'b0;
              end
              OP_RDMR: begin
                // First mode bit is already on the wire for the next edge.
                state_d = S_MRD;
                miso_d  = mode_q[1];
                tx_d    = {mode_q[0], 7'b0};
                bit_d   = 3'd1;
              end
              OP_WRMR: state_d = S_MWR;
              default: state_d = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(AW - 1)) begin
            addr_d = rx_next;
            cnt_d  = '0;
            bit_d  = '0;
            if (is_rd_q) begin
              state_d = S_GAP;
              if (READ_GAP == 2) mem_en_d = 1'b1;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_GAP: begin
          cnt_d = cnt_q + 1'b1;
          if ((READ_GAP > 2) && (cnt_q == CW'(PF_CNT))) mem_en_d = 1'b1;
          if (cnt_q == CW'(READ_GAP - 1)) begin
            state_d = S_RDATA;
            miso_d  = mem_rdata[7];
            tx_d    = {mem_rdata[6:0], 1'b0};
            bit_d   = 3'd1;
          end
        end
        S_RDATA: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd0) begin
            if (mode_q == MODE_BYTE) begin
              state_d = S_IGNORE;
            end else begin
              miso_d = mem_rdata[7];
              tx_d   = {mem_rdata[6:0], 1'b0};
            end
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            // Prefetch early enough that the next byte loads on the bit-0 edge.
            if ((bit_q == 3'd6) && (mode_q != MODE_BYTE)) begin
              mem_en_d = 1'b1;
              addr_d   = next_addr(addr_q, mode_q);
            end
          end
        end
        S_WDATA: begin
          bit_d = bit_q + 3'd1;
          if (mem_en_q) addr_d = next_addr(addr_q, mode_q);
          if (bit_q == 3'd7) begin
            mem_en_d = 1'b1;
            mem_wr_d = 1'b1;
            wdata_d  = rx_next[7:0];
            if (mode_q == MODE_BYTE) state_d = S_IGNORE;
          end
        end
        S_MRD: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd0) begin
            miso_d = mode_q[1];
            tx_d   = {mode_q[0], 7'b0};
          end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        S_MWR: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            mode_d  = rx_next[7:6];
            state_d = S_IGNORE;
          end
        end
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      mode_q   <= MODE_SEQ;
      miso_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      is_rd_q  <= is_rd_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      miso_q   <= miso_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Shift registers carry only data; their contents are qualified by the FSM.
  always_ff @(posedge clk) begin
    rx_q <= rx_next;
    tx_q <= tx_d;
  end

endmodule
